ef_smsdac_mse_gen: RTL

//  Parametrised segmented mismatch-shaping encoder for the segmented DAC.

---
 rtl/ef_smsdac_pkg.sv | 33 +++
 rtl/ef_smsdac_mse_stg.sv | 64 ++++++
 rtl/ef_smsdac_mse_gen.sv | 76 +++++++
 3 files changed

// File: rtl/ef_smsdac_pkg.sv
// rtl/ef_smsdac_pkg.sv - shared constants and helpers for the segmented mismatch-shaping encoder

package ef_smsdac_pkg;

  typedef enum logic [1:0] {
    MODE_BYP    = 2'b00,
    MODE_EXT    = 2'b01,
    MODE_LFSR   = 2'b10,
    MODE_NODITH = 2'b11
  } mode_e;

  localparam logic [1:0] Y_POS  = 2'b10;
  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_NEG  = 2'b01;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Both operands are in {-1,0,+1}; result clamps to the same range
  function automatic logic signed [1:0] sat_add(input logic signed [1:0] a,
                                                input logic signed [1:0] b);
    logic signed [2:0] s;
    s = {a[1], a} + {b[1], b};
    if (s > 3'sd1)       return 2'sb01;
    else if (s < -3'sd1) return 2'sb11;
    else                 return s[1:0];
  endfunction

endpackage

// File: rtl/ef_smsdac_mse_stg.sv
// rtl/ef_smsdac_mse_stg.sv - one 3-level stage: decision, carry and shaping state

module ef_smsdac_mse_stg
  import ef_smsdac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       clr,
  input  logic       upd,
  input  mode_e      mode,
  input  logic       x_bit,
  input  logic       c_in,
  input  logic       d_bit,
  output logic [1:0] y,
  output logic       c_out
);

  logic signed [1:0] acc;
  logic signed [1:0] y_val;
  logic              pick_pos;

  always_comb begin
    y        = Y_ZERO;
    y_val    = 2'sb00;
    c_out    = 1'b0;
    pick_pos = 1'b1;
    if (mode != MODE_BYP) begin
      if (acc == 2'sb01)      pick_pos = 1'b0;
      else if (acc == 2'sb11) pick_pos = 1'b1;
      else                    pick_pos = d_bit;
    end
    case ({x_bit, c_in})
      2'b10: c_out = 1'b1;
      2'b11: begin
        y     = Y_POS;
        y_val = 2'sb01;
        c_out = 1'b1;
      end
      2'b01: begin
        // v=1 is the only free choice: +1 with no carry, or -1 and borrow from the next stage
        if (pick_pos) begin
          y     = Y_POS;
          y_val = 2'sb01;
        end else begin
          y     = Y_NEG;
          y_val = 2'sb11;
          c_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc <= 2'sb00;
    end else if (clr) begin
      acc <= 2'sb00;
    end else if (upd && c_in && (mode != MODE_BYP)) begin
      acc <= sat_add(acc, y_val);
    end
  end

endmodule

// File: rtl/ef_smsdac_mse_gen.sv
// rtl/ef_smsdac_mse_gen.sv - segmented mismatch-shaping encoder top: stage chain, LFSR and output registers

module ef_smsdac_mse_gen
  import ef_smsdac_pkg::*;
#(
  parameter int          N_STG     = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               clr,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic [N_STG-1:0]   x,
  input  logic               x_c,
  input  logic [N_STG-1:0]   r,
  output logic               out_valid,
  output logic [2*N_STG-1:0] y,
  output logic               y_c
);

  mode_e              mode_s;
  logic               accept;
  logic [15:0]        lfsr;
  logic [N_STG-1:0]   d;
  logic [N_STG:0]     c;
  logic [2*N_STG-1:0] y_nxt;

  assign mode_s = mode_e'(mode);
  assign accept = in_valid & ~clr;
  assign c[0]   = x_c;

  always_comb begin
    d = '1;
    case (mode_s)
      MODE_EXT:  d = r;
      MODE_LFSR: d = lfsr[N_STG-1:0];
      default:   d = '1;
    endcase
  end

  // Carry ripples LSB to MSB so the whole code resolves in one cycle
  for (genvar k = 0; k < N_STG; k++) begin : g_stg
    ef_smsdac_mse_stg u_stg (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (clr),
      .upd   (accept),
      .mode  (mode_s),
      .x_bit (x[k]),
      .c_in  (c[k]),
      .d_bit (d[k]),
      .y     (y_nxt[2*k+:2]),
      .c_out (c[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_c       <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      out_valid <= accept;
      if (clr) begin
        lfsr <= LFSR_SEED;
      end else if (accept) begin
        lfsr <= lfsr_next(lfsr);
        y    <= y_nxt;
        y_c  <= c[N_STG];
      end
    end
  end

endmodule
